// File: rtl/group_event_arbiter.sv
// -----------------------------------------------------------------------------
// group_event_arbiter
//
// Round-robin arbiter for 16 pixel groups, arranged as a 4x4 grid. It grants
// one group at a time, moves each pixel event from that group into a
// valid/ready event channel, and takes the grant back when one of these
// happens:
//   - the group reports that its burst is finished, or
//   - the group stays silent for TIMEOUT_CYCLES grant cycles.
//
// Group i maps to req[i/4][i%4]. The same bit mapping is used for in_gnt_o and
// gnt_o, and bit i of grp_release belongs to group i.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous, active-high reset
//   req            [3:0][3:0] group requests
//   grp_release    [15:0] group i has finished its burst
//   in_gnt_o       [3:0][3:0] pixel grant from the granted group (nonzero = valid)
//   in_x_add       [1:0] pixel column inside the granted group
//   in_y_add       [1:0] pixel row inside the granted group
//   timestamp_in   [31:0] pixel event timestamp
//   polarity_in    pixel event polarity
//   gnt_o          [3:0][3:0] registered one-hot group grant
//   evt_valid      event available downstream
//   evt_ready      downstream accepts the event
//   evt_x, evt_y   [3:0] global pixel coordinates {group col/row, pixel addr}
//   evt_timestamp  [31:0] captured timestamp
//   evt_polarity   captured polarity
//   busy           arbiter is not idle
//   timeout_err    one-cycle pulse when a grant is revoked by the timeout
// -----------------------------------------------------------------------------
module group_event_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0][3:0]  req,
  input  logic [15:0]      grp_release,
  input  logic [3:0][3:0]  in_gnt_o,
  input  logic [1:0]       in_x_add,
  input  logic [1:0]       in_y_add,
  input  logic [31:0]      timestamp_in,
  input  logic             polarity_in,
  output logic [3:0][3:0]  gnt_o,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [3:0]       evt_x,
  output logic [3:0]       evt_y,
  output logic [31:0]      evt_timestamp,
  output logic             evt_polarity,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_OUTPUT  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Last counter value that is still a legal GRANT cycle. When the counter
  // holds this value and the group is still silent, this GRANT cycle is the
  // TIMEOUT_CYCLES-th one, so the grant is revoked.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  ptr_q;        // round-robin search start
  logic [3:0]  owner_q;      // currently granted group
  logic [7:0]  silent_cnt_q; // GRANT cycles since entry or last capture
  logic        pend_q;       // sticky: owner asked to release

  logic [15:0] req_flat;
  logic        any_req;
  logic [3:0]  winner;
  logic        pixel_valid;
  logic        owner_release;
  logic        timeout_hit;
  logic        capture;
  logic        timeout_fire;

  assign req_flat      = req;
  assign any_req       = |req_flat;
  assign pixel_valid   = |in_gnt_o;
  assign owner_release = grp_release[owner_q];
  assign timeout_hit   = (silent_cnt_q == TIMEOUT_LAST);
  assign busy          = (state_q != S_IDLE);

  // Round-robin search. The loop runs backwards, from the farthest candidate
  // to ptr itself, so the last match written is the one closest to ptr.
  always_comb begin
    winner = ptr_q;
    for (int k = 15; k >= 0; k--) begin
      if (req_flat[ptr_q + 4'(k)]) begin
        winner = ptr_q + 4'(k);
      end
    end
  end

  // Next-state logic.
  // NOTE: every signal written here gets a default first. Without it, a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    timeout_fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // A pixel capture wins over a same-cycle release. The release stays
        // pending and is acted on after the handshake.
        if (pixel_valid) begin
          state_d = S_OUTPUT;
          capture = 1'b1;
        end else if (pend_q || owner_release) begin
          state_d = S_RELEASE;
        end else if (timeout_hit) begin
          state_d      = S_RELEASE;
          timeout_fire = 1'b1;
        end
      end
      S_OUTPUT: begin
        if (evt_ready) begin
          state_d = (pend_q || owner_release) ? S_RELEASE : S_GRANT;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and the one-cycle timeout pulse.
  // NOTE: sequential state uses non-blocking assignments, so every flop here
  // samples the values from before the edge, whatever order the statements
  // are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      timeout_err <= timeout_fire;
    end
  end

  // Grant ownership, the registered one-hot grant, and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= 4'd0;
      owner_q <= 4'd0;
      gnt_o   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            gnt_o   <= 16'(1) << winner;
          end
        end
        S_GRANT, S_OUTPUT: begin
          // The grant does not depend on req once it is issued. It falls only
          // when the FSM heads into RELEASE.
          if (state_d == S_RELEASE) begin
            gnt_o <= '0;
          end
        end
        S_RELEASE: begin
          ptr_q <= owner_q + 4'd1;
          gnt_o <= '0;
        end
        default: begin
          gnt_o <= '0;
        end
      endcase
    end
  end

  // Silent-cycle counter and the sticky release request.
  always_ff @(posedge clk) begin
    if (rst) begin
      silent_cnt_q <= 8'd0;
      pend_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          silent_cnt_q <= 8'd0;
          pend_q       <= 1'b0;
        end
        S_GRANT: begin
          if (capture) begin
            silent_cnt_q <= 8'd0;
          end else if (!timeout_hit) begin
            silent_cnt_q <= silent_cnt_q + 8'd1;
          end
          if (owner_release) begin
            pend_q <= 1'b1;
          end
        end
        S_OUTPUT: begin
          // The counter is frozen while waiting for the handshake.
          if (owner_release) begin
            pend_q <= 1'b1;
          end
        end
        S_RELEASE: begin
          silent_cnt_q <= 8'd0;
          pend_q       <= 1'b0;
        end
        default: begin
          silent_cnt_q <= 8'd0;
          pend_q       <= 1'b0;
        end
      endcase
    end
  end

  // Event register. It is loaded only on a GRANT-state capture, so in_gnt_o
  // is ignored while an event is waiting.
  // NOTE: the event payload is reset together with evt_valid. A reset during
  // OUTPUT then discards the event and leaves no stale data on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid     <= 1'b0;
      evt_x         <= 4'd0;
      evt_y         <= 4'd0;
      evt_timestamp <= 32'd0;
      evt_polarity  <= 1'b0;
    end else if (capture) begin
      evt_valid     <= 1'b1;
      evt_x         <= {owner_q[1:0], in_x_add};
      evt_y         <= {owner_q[3:2], in_y_add};
      evt_timestamp <= timestamp_in;
      evt_polarity  <= polarity_in;
    end else if (state_q == S_OUTPUT && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_group_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_group_event_arbiter
//
// Directed scenarios followed by a randomized phase. Every cycle, the outputs
// are compared against a behavioural reference model built from the arbiter's
// rules:
//   - a grant owner, given as a group index,
//   - an outstanding-event flag,
//   - a release-cycle flag,
//   - a count of silent grant cycles,
//   - the next round-robin start index.
// -----------------------------------------------------------------------------
module tb_group_event_arbiter;

  localparam int TIMEOUT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][3:0] req;
  logic [15:0]     grp_release;
  logic [3:0][3:0] in_gnt_o;
  logic [1:0]      in_x_add;
  logic [1:0]      in_y_add;
  logic [31:0]     timestamp_in;
  logic            polarity_in;
  logic [3:0][3:0] gnt_o;
  logic            evt_valid;
  logic            evt_ready;
  logic [3:0]      evt_x;
  logic [3:0]      evt_y;
  logic [31:0]     evt_timestamp;
  logic            evt_polarity;
  logic            busy;
  logic            timeout_err;

  always #5 clk = ~clk;

  group_event_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .grp_release   (grp_release),
    .in_gnt_o      (in_gnt_o),
    .in_x_add      (in_x_add),
    .in_y_add      (in_y_add),
    .timestamp_in  (timestamp_in),
    .polarity_in   (polarity_in),
    .gnt_o         (gnt_o),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_x         (evt_x),
    .evt_y         (evt_y),
    .evt_timestamp (evt_timestamp),
    .evt_polarity  (evt_polarity),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          m_owner  = -1;   // granted group, -1 when idle
  bit          m_event  = 1'b0; // event waiting for downstream
  bit          m_rel    = 1'b0; // in the single release cycle
  bit          m_pend   = 1'b0; // owner asked to release
  bit          m_tmo    = 1'b0; // timeout pulse this cycle
  int          m_silent = 0;    // silent grant cycles so far
  int          m_start  = 0;    // round-robin start
  logic [3:0]  m_x      = '0;
  logic [3:0]  m_y      = '0;
  logic [31:0] m_ts     = '0;
  logic        m_pol    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int start);
    for (int k = 0; k < 16; k++) begin
      if (r[(start + k) % 16]) return (start + k) % 16;
    end
    return -1;
  endfunction

  // Advance the model by one rising edge, using the inputs present at the edge.
  task automatic model_edge();
    logic [15:0] r;
    logic [15:0] rel;
    logic [15:0] ig;
    r     = req;
    rel   = grp_release;
    ig    = in_gnt_o;
    m_tmo = 1'b0;
    if (rst) begin
      m_owner = -1; m_event = 0; m_rel = 0; m_pend = 0; m_silent = 0; m_start = 0;
      m_x = '0; m_y = '0; m_ts = '0; m_pol = 1'b0;
    end else if (m_rel) begin
      m_rel = 0; m_owner = -1; m_pend = 0;
    end else if (m_owner < 0) begin
      m_owner  = pick(r, m_start);
      m_silent = 0;
    end else if (m_event) begin
      if (rel[m_owner]) m_pend = 1;
      if (evt_ready) begin
        m_event = 0;
        if (m_pend) begin
          m_rel = 1; m_start = (m_owner + 1) % 16;
        end
      end
    end else if (ig != 16'h0) begin
      m_event  = 1;
      m_silent = 0;
      if (rel[m_owner]) m_pend = 1;
      m_x   = 4'((m_owner % 4) * 4 + int'(in_x_add));
      m_y   = 4'((m_owner / 4) * 4 + int'(in_y_add));
      m_ts  = timestamp_in;
      m_pol = polarity_in;
    end else if (m_pend || rel[m_owner]) begin
      m_rel = 1; m_start = (m_owner + 1) % 16;
    end else if (m_silent + 1 >= TIMEOUT) begin
      m_rel = 1; m_tmo = 1; m_start = (m_owner + 1) % 16;
    end else begin
      m_silent++;
    end
  endtask

  task automatic check_model();
    logic [15:0] eg;
    eg = '0;
    if (m_owner >= 0 && !m_rel) eg[m_owner] = 1'b1;
    check("model_gnt_o", 32'(gnt_o), 32'(eg));
    check("model_evt_valid", 32'(evt_valid), 32'(m_event));
    check("model_busy", 32'(busy), 32'(m_owner >= 0));
    check("model_timeout_err", 32'(timeout_err), 32'(m_tmo));
    if (m_event) begin
      check("model_evt_x", 32'(evt_x), 32'(m_x));
      check("model_evt_y", 32'(evt_y), 32'(m_y));
      check("model_evt_ts", evt_timestamp, m_ts);
      check("model_evt_pol", 32'(evt_polarity), 32'(m_pol));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic clear_inputs();
    rst          = 1'b0;
    req          = '0;
    grp_release  = '0;
    in_gnt_o     = '0;
    in_x_add     = '0;
    in_y_add     = '0;
    timestamp_in = '0;
    polarity_in  = 1'b0;
    evt_ready    = 1'b0;
  endtask

  initial begin
    int vcount;
    logic [15:0] exp_g;

    // Reset state
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_evt_x", 32'(evt_x), 32'h0);
    check("rst_evt_ts", evt_timestamp, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Groups 5 and 9 request with ptr 0: group 5 first, then group 9 after release
    req = 16'h0220;
    step();
    check("rr_first_gnt", 32'(gnt_o), 32'h0020);
    grp_release = 16'h0020;
    step();
    grp_release = '0;
    check("rr_release_gnt_low", 32'(gnt_o), 32'h0);
    step();
    check("rr_idle_busy", 32'(busy), 32'h0);
    step();
    check("rr_second_gnt", 32'(gnt_o), 32'h0200);
    req = '0;

    // Group 9 stays silent: revoked after 4 grant cycles with a single pulse
    for (int i = 0; i < 3; i++) begin
      step();
      check("tmo_still_granted", 32'(gnt_o), 32'h0200);
    end
    step();
    check("tmo_pulse", 32'(timeout_err), 32'h1);
    check("tmo_gnt_low", 32'(gnt_o), 32'h0);
    step();
    check("tmo_pulse_end", 32'(timeout_err), 32'h0);

    // Group 6 capture, ready held low for 3 cycles
    req = 16'h0040;
    step();
    check("evt_gnt6", 32'(gnt_o), 32'h0040);
    req          = '0;
    in_gnt_o     = 16'h0001;
    in_x_add     = 2'd3;
    in_y_add     = 2'd1;
    timestamp_in = 32'h1234;
    polarity_in  = 1'b1;
    step();
    vcount = 0;
    if (evt_valid) vcount++;
    check("evt_x_0xB", 32'(evt_x), 32'hB);
    check("evt_y_0x5", 32'(evt_y), 32'h5);
    // A pixel arriving while the event waits must be ignored
    in_x_add     = 2'd0;
    in_y_add     = 2'd2;
    timestamp_in = 32'hDEAD;
    polarity_in  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (evt_valid) vcount++;
      check("evt_hold_x", 32'(evt_x), 32'hB);
      check("evt_hold_ts", evt_timestamp, 32'h1234);
    end
    evt_ready = 1'b1;
    in_gnt_o  = '0;
    step();
    check("evt_valid_cycles", 32'(vcount), 32'd4);
    check("evt_dropped", 32'(evt_valid), 32'h0);
    check("evt_grant_kept", 32'(gnt_o), 32'h0040);
    evt_ready   = 1'b0;
    grp_release = 16'h0040;
    step();
    grp_release = '0;
    step();

    // Same-cycle release and capture on group 12
    req = 16'h1000;
    step();
    check("same_gnt12", 32'(gnt_o), 32'h1000);
    req         = '0;
    in_gnt_o    = 16'h8000;
    grp_release = 16'h1000;
    in_x_add    = 2'd1;
    in_y_add    = 2'd2;
    evt_ready   = 1'b1;
    step();
    check("same_evt_valid", 32'(evt_valid), 32'h1);
    check("same_evt_x", 32'(evt_x), 32'h1);
    check("same_evt_y", 32'(evt_y), 32'hE);
    in_gnt_o    = '0;
    grp_release = '0;
    step();
    check("same_release_gnt", 32'(gnt_o), 32'h0);
    check("same_release_valid", 32'(evt_valid), 32'h0);
    step();
    req = 16'h3000;
    step();
    check("same_ptr_next", 32'(gnt_o), 32'h2000);
    req         = '0;
    grp_release = 16'h2000;
    step();
    grp_release = '0;
    evt_ready   = 1'b0;
    step();

    // Reset while an event is pending
    req = 16'h0008;
    step();
    check("rstevt_gnt3", 32'(gnt_o), 32'h0008);
    req      = '0;
    in_gnt_o = 16'h0010;
    step();
    check("rstevt_valid", 32'(evt_valid), 32'h1);
    in_gnt_o = '0;
    rst      = 1'b1;
    step();
    check("rstevt_gnt_low", 32'(gnt_o), 32'h0);
    check("rstevt_valid_low", 32'(evt_valid), 32'h0);
    rst       = 1'b0;
    evt_ready = 1'b1;
    step();
    check("rstevt_no_event", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;

    // All groups requesting: visit 0..15, then wrap to 0
    req = 16'hFFFF;
    for (int g = 0; g < 17; g++) begin
      step();
      exp_g = '0;
      exp_g[g % 16] = 1'b1;
      check("sweep_gnt", 32'(gnt_o), 32'(exp_g));
      grp_release = exp_g;
      step();
      grp_release = '0;
      step();
    end
    req = '0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      req          = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      grp_release  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0;
      in_gnt_o     = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
      in_x_add     = 2'($urandom);
      in_y_add     = 2'($urandom);
      timestamp_in = $urandom;
      polarity_in  = 1'($urandom);
      evt_ready    = 1'($urandom);
      step();
    end

    clear_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
